sevenseg4d_capture: RTL

//  Receive-side counterpart of the 4-digit seven-segment driver: samples a time-multiplexed

---
 rtl/sevenseg_pkg.sv | 52 +++++
 rtl/sevenseg_glyph_decode.sv | 18 +
 rtl/sevenseg4d_capture.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - glyph constants, capture FSM states and glyph-to-hex decode for the seven-segment capture block
// Contents: GLYPH_0..GLYPH_F (active-high, bit0=a .. bit6=g), IDLE/SETTLE/CAPTURED state codes,
//           glyph_to_hex(glyph) -> {ok, nibble}; unknown patterns return 5'b0_0000.
package sevenseg_pkg;

   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   typedef logic [1:0] cap_state_t;
   localparam cap_state_t IDLE     = 2'd0;
   localparam cap_state_t SETTLE   = 2'd1;
   localparam cap_state_t CAPTURED = 2'd2;

   function automatic logic [4:0] glyph_to_hex(input logic [6:0] glyph);
      logic [4:0] res;
      case (glyph)
         GLYPH_0: res = {1'b1, 4'h0};
         GLYPH_1: res = {1'b1, 4'h1};
         GLYPH_2: res = {1'b1, 4'h2};
         GLYPH_3: res = {1'b1, 4'h3};
         GLYPH_4: res = {1'b1, 4'h4};
         GLYPH_5: res = {1'b1, 4'h5};
         GLYPH_6: res = {1'b1, 4'h6};
         GLYPH_7: res = {1'b1, 4'h7};
         GLYPH_8: res = {1'b1, 4'h8};
         GLYPH_9: res = {1'b1, 4'h9};
         GLYPH_A: res = {1'b1, 4'hA};
         GLYPH_B: res = {1'b1, 4'hB};
         GLYPH_C: res = {1'b1, 4'hC};
         GLYPH_D: res = {1'b1, 4'hD};
         GLYPH_E: res = {1'b1, 4'hE};
         GLYPH_F: res = {1'b1, 4'hF};
         default: res = 5'b0_0000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// rtl/sevenseg_glyph_decode.sv - combinational decode of one active-high seven-segment pattern
// Ports: glyph [6:0] in  - active-high pattern, bit0=a .. bit6=g
//        value [3:0] out - hex nibble, 0 when the pattern is not a hex glyph
//        ok          out - 1 when the pattern is a legal hex glyph
module sevenseg_glyph_decode (
   input  logic [6:0] glyph,
   output logic [3:0] value,
   output logic       ok
);
   import sevenseg_pkg::*;

   logic [4:0] res;

   assign res   = glyph_to_hex(glyph);
   assign ok    = res[4];
   assign value = res[3:0];

endmodule

// File: rtl/sevenseg4d_capture.sv
// rtl/sevenseg4d_capture.sv - reconstructs four digit patterns from a muxed seven-segment bus
// Ports: clk, rst (async, active-high); segments [6:0] active-low muxed bus; anodes [3:0] one-hot strobes
//        digit0..3_segments [6:0] captured active-high patterns; digit_values [15:0] hex nibbles;
//        digit_ok [3:0] legal-glyph flags; frame_valid 1-cycle update pulse; display_lost capture timeout
// Option: SEVENSEG_CAP_STATS_EN adds err_count [7:0] (illegal strobes held >=2 cycles + bad frame digits)
module sevenseg4d_capture #(
   parameter int SETTLE_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES   = 16384,
   parameter int ANODE_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  segments,
   input  logic [3:0]  anodes,
   output logic [6:0]  digit0_segments,
   output logic [6:0]  digit1_segments,
   output logic [6:0]  digit2_segments,
   output logic [6:0]  digit3_segments,
   output logic [15:0] digit_values,
   output logic [3:0]  digit_ok,
   output logic        frame_valid,
`ifdef SEVENSEG_CAP_STATS_EN
   output logic [7:0]  err_count,
`endif
   output logic        display_lost
);
   import sevenseg_pkg::*;

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [6:0] seg_s1, seg_s2;
   logic [3:0] an_s1, an_s2;
   logic [6:0] seg_act;
   logic [3:0] strobe;
   logic       legal;

   cap_state_t    state;
   logic [SW-1:0] cnt;
   logic [3:0]    cur;
   logic          capture;
   logic [3:0]    mask;
   logic          frame_now;
   logic [6:0]    shadow [4];
   logic [3:0]    dval [4];
   logic [3:0]    dok;
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_s1 <= '0;
         seg_s2 <= '0;
         an_s1  <= '0;
         an_s2  <= '0;
      end else begin
         seg_s1 <= segments;
         seg_s2 <= seg_s1;
         an_s1  <= anodes;
         an_s2  <= an_s1;
      end
   end

   assign seg_act = ~seg_s2;
   assign strobe  = (ANODE_ACTIVE_LOW != 0) ? ~an_s2 : an_s2;
   assign legal   = (strobe != 4'b0000) && ((strobe & (strobe - 4'd1)) == 4'b0000);

   // cnt counts the stable cycles already seen, so the capture fires on the
   // SETTLE_CYCLES-th cycle; a strobe change on that cycle blocks it.
   assign capture = (state == SETTLE) && (strobe == cur) && (cnt == SW'(SETTLE_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cur   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (legal) begin
                  state <= SETTLE;
                  cnt   <= SW'(1);
                  cur   <= strobe;
               end
            end
            SETTLE: begin
               if (strobe != cur) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (capture) begin
                  state <= CAPTURED;
                  cnt   <= SW'(SETTLE_CYCLES);
               end else begin
                  cnt <= cnt + SW'(1);
               end
            end
            CAPTURED: begin
               // A direct hop to another legal strobe starts settling this cycle.
               if (strobe != cur) begin
                  if (legal) begin
                     state <= SETTLE;
                     cnt   <= SW'(1);
                     cur   <= strobe;
                  end else begin
                     state <= IDLE;
                     cnt   <= '0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dec
         sevenseg_glyph_decode u_dec (
            .glyph (shadow[gi]),
            .value (dval[gi]),
            .ok    (dok[gi])
         );
      end
   endgenerate

   assign frame_now = (mask == 4'hF);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) shadow[i] <= '0;
         mask            <= '0;
         frame_valid     <= 1'b0;
         digit0_segments <= '0;
         digit1_segments <= '0;
         digit2_segments <= '0;
         digit3_segments <= '0;
         digit_values    <= '0;
         digit_ok        <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (capture && cur[i]) shadow[i] <= seg_act;
         end
         // Newest capture of an already-masked digit just overwrites its shadow.
         mask        <= (frame_now ? 4'h0 : mask) | (capture ? cur : 4'h0);
         frame_valid <= frame_now;
         if (frame_now) begin
            digit0_segments <= shadow[0];
            digit1_segments <= shadow[1];
            digit2_segments <= shadow[2];
            digit3_segments <= shadow[3];
            digit_values    <= {dval[3], dval[2], dval[1], dval[0]};
            digit_ok        <= dok;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (capture) begin
         to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   assign display_lost = (to_cnt == TW'(TIMEOUT_CYCLES));

`ifdef SEVENSEG_CAP_STATS_EN
   logic [3:0] prev_strobe;
   logic       ill_held;
   logic       ill_counted;
   logic       ill_hit;
   logic [2:0] bad_digits;
   logic [8:0] err_sum;

   // An illegal non-zero pattern counts once, on its second consecutive cycle.
   assign ill_held = !legal && (strobe != 4'b0000) && (strobe == prev_strobe);
   assign ill_hit  = ill_held && !ill_counted;

   always_comb begin
      bad_digits = '0;
      if (frame_now) begin
         for (int i = 0; i < 4; i++) begin
            if (!dok[i]) bad_digits = bad_digits + 3'd1;
         end
      end
   end

   assign err_sum = {1'b0, err_count} + 9'(ill_hit) + 9'(bad_digits);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_strobe <= '0;
         ill_counted <= 1'b0;
         err_count   <= '0;
      end else begin
         prev_strobe <= strobe;
         ill_counted <= ill_held;
         err_count   <= err_sum[8] ? 8'hFF : err_sum[7:0];
      end
   end
`endif

endmodule
